// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
//   Circular FIFO of free physical-register tags that sits between the ROB
//   retire port and the rename stage. Rename pops one tag per cycle from the
//   head. The ROB pushes up to two reclaimed tags per cycle at the tail.
//   Tag 0 means "no tag" and is never stored.
//
// Ports
//   clk            : clock; all state updates on the rising edge
//   reset          : synchronous, active-high reset
//   alloc_enable   : rename consumes alloc_tag this cycle
//   alloc_tag      : tag at the head, shown ahead of the pop; 0 when empty
//   alloc_valid    : list is non-empty, so alloc_tag is usable
//   freed_tag_1    : first tag retired by the ROB (0 = none)
//   freed_tag_2    : second tag retired by the ROB (0 = none)
//   free_count     : number of tags currently in the list
//   overflow_error : sticky; a free was dropped because the list was full
module phys_reg_free_list #(
  parameter int TAG_WIDTH      = 6,
  parameter int NUM_TAGS       = 64,
  parameter int FIRST_FREE_TAG = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_enable,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 alloc_valid,
  input  logic [TAG_WIDTH-1:0] freed_tag_1,
  input  logic [TAG_WIDTH-1:0] freed_tag_2,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 overflow_error
);

  localparam int PTR_W = $clog2(NUM_TAGS);
  localparam int CNT_W = TAG_WIDTH + 1;
  localparam int INIT_FREE = NUM_TAGS - FIRST_FREE_TAG;
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(NUM_TAGS);
  localparam logic [CNT_W-1:0] INIT_CNT  = CNT_W'(INIT_FREE);
  localparam logic [PTR_W-1:0] INIT_TAIL = PTR_W'(INIT_FREE % NUM_TAGS);

  logic [TAG_WIDTH-1:0] storage [NUM_TAGS];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 overflow;

  logic                 do_alloc;
  logic [CNT_W-1:0]     base;
  logic                 accept_1;
  logic                 accept_2;
  logic                 dropped;
  logic [1:0]           nacc;
  logic [PTR_W-1:0]     wr_ptr_2;

  // Advance a pointer by 0..2 slots, wrapping modulo NUM_TAGS (which need
  // not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(NUM_TAGS))
      s = s - (PTR_W+1)'(NUM_TAGS);
    return s[PTR_W-1:0];
  endfunction

  assign alloc_valid    = (count != '0);
  assign alloc_tag      = alloc_valid ? storage[head] : '0;
  assign free_count     = count;
  assign overflow_error = overflow;

  always_comb begin
    do_alloc = alloc_enable && (count != '0);
    // A same-cycle allocation frees a slot before the frees are considered,
    // and freed_tag_1 claims space ahead of freed_tag_2.
    base     = count - CNT_W'(do_alloc);
    accept_1 = (freed_tag_1 != '0) && (base < DEPTH);
    accept_2 = (freed_tag_2 != '0) && ((base + CNT_W'(accept_1)) < DEPTH);
    dropped  = ((freed_tag_1 != '0) && !accept_1) ||
               ((freed_tag_2 != '0) && !accept_2);
    nacc     = 2'(accept_1) + 2'(accept_2);
    // freed_tag_2 lands right after freed_tag_1, or at the tail itself when
    // freed_tag_1 is absent or dropped.
    wr_ptr_2 = ptr_add(tail, 2'(accept_1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= INIT_TAIL;
      count    <= INIT_CNT;
      overflow <= 1'b0;
      for (int i = 0; i < INIT_FREE; i++)
        storage[i] <= TAG_WIDTH'(FIRST_FREE_TAG + i);
    end else begin
      if (do_alloc)
        head <= ptr_add(head, 2'd1);
      if (accept_1)
        storage[tail] <= freed_tag_1;
      if (accept_2)
        storage[wr_ptr_2] <= freed_tag_2;
      tail  <= ptr_add(tail, nacc);
      count <= count + CNT_W'(nacc) - CNT_W'(do_alloc);
      if (dropped)
        overflow <= 1'b1;
    end
  end

endmodule
